// File: rtl/multi_channel_sampler.sv
// multi_channel_sampler
//   Captures CHANNELS parallel WIDTH-bit audio samples once every SAMPLE_DIV
//   enabled clocks. Each captured frame is either the samples present in the
//   capture cycle (AVERAGE=0) or the box average over the window (AVERAGE=1).
//   Frames go into a small FIFO with a 32-bit frame stamp and are presented on
//   a valid/ready stream.
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : 1 = sampling runs, 0 = divider and accumulators hold
//   samples_in : live samples, channel c at [c*WIDTH +: WIDTH]
//   out_valid  : head frame available
//   out_ready  : consumer takes the head when out_valid & out_ready
//   out_data   : head frame samples (last popped frame while empty)
//   out_stamp  : frame index of the head frame (last popped while empty)
//   fifo_level : frames currently held, 0..FIFO_DEPTH
//   overflow   : sticky, a frame was dropped since reset
module multi_channel_sampler #(
  parameter int WIDTH      = 4,
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_DIV = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int AVERAGE    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [CHANNELS*WIDTH-1:0]         samples_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNELS*WIDTH-1:0]         out_data,
  output logic [31:0]                       out_stamp,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int ACC_W  = WIDTH + DIV_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int DATA_W = CHANNELS * WIDTH;

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] div_cnt_reg;
  logic             strobe;

  assign strobe = en && (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));

  // SAMPLE_DIV is a power of two, so the natural wrap of the counter is the
  // 0..SAMPLE_DIV-1 sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (en) begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // ------------------------------------------------------- frame generation
  logic [DATA_W-1:0] frame;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      if (AVERAGE != 0) begin : g_avg
        logic [ACC_W-1:0] acc_reg;
        logic [ACC_W-1:0] sum;

        // The strobe-cycle sample is folded into the output sum, so the window
        // holds exactly SAMPLE_DIV samples; ACC_W cannot overflow on it.
        assign sum = acc_reg + ACC_W'(samples_in[gi*WIDTH +: WIDTH]);
        assign frame[gi*WIDTH +: WIDTH] = sum[ACC_W-1:DIV_W];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            acc_reg <= '0;
          end else if (en) begin
            acc_reg <= strobe ? '0 : sum;
          end
        end
      end else begin : g_point
        assign frame[gi*WIDTH +: WIDTH] = samples_in[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  // ------------------------------------------------------------ frame stamp
  logic [31:0] frame_cnt_reg;

  // Counts every strobe, stored or not, so drops appear as stamp gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (strobe) begin
      frame_cnt_reg <= frame_cnt_reg + 32'd1;
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem_data  [FIFO_DEPTH];
  logic [31:0]       mem_stamp [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] last_data_reg;
  logic [31:0]       last_stamp_reg;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full = (level_reg == LVL_W'(FIFO_DEPTH));
  assign pop  = (level_reg != '0) && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = strobe && (!full || pop);
  assign drop = strobe && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg]  <= frame;
      mem_stamp[wr_ptr_reg] <= frame_cnt_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      last_data_reg  <= '0;
      last_stamp_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
        last_data_reg  <= mem_data[rd_ptr_reg];
        last_stamp_reg <= mem_stamp[rd_ptr_reg];
      end
      level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // While empty the stream shows the most recently popped frame.
  assign out_valid  = (level_reg != '0);
  assign out_data   = out_valid ? mem_data[rd_ptr_reg]  : last_data_reg;
  assign out_stamp  = out_valid ? mem_stamp[rd_ptr_reg] : last_stamp_reg;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_multi_channel_sampler.sv
// Bench for multi_channel_sampler: a point-sampling and an averaging instance
// share one stimulus stream; a scoreboard queue of expected frames is filled
// when strobes are driven and compared against the stream head every cycle.
module tb_multi_channel_sampler;

  localparam int W     = 4;
  localparam int CH    = 2;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = CH * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] samples = '0;

  logic          valid_pt, valid_avg;
  logic [DW-1:0] data_pt, data_avg;
  logic [31:0]   stamp_pt, stamp_avg;
  logic [2:0]    level_pt, level_avg;
  logic          ovf_pt, ovf_avg;

  always #5 clk = ~clk;

  multi_channel_sampler #(
    .WIDTH(W), .CHANNELS(CH), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH), .AVERAGE(0)
  ) dut_pt (
    .clk(clk), .rst(rst), .en(en), .samples_in(samples),
    .out_valid(valid_pt), .out_ready(ready), .out_data(data_pt),
    .out_stamp(stamp_pt), .fifo_level(level_pt), .overflow(ovf_pt)
  );

  multi_channel_sampler #(
    .WIDTH(W), .CHANNELS(CH), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH), .AVERAGE(1)
  ) dut_avg (
    .clk(clk), .rst(rst), .en(en), .samples_in(samples),
    .out_valid(valid_avg), .out_ready(ready), .out_data(data_avg),
    .out_stamp(stamp_avg), .fifo_level(level_avg), .overflow(ovf_avg)
  );

  typedef struct {
    logic [DW-1:0] pt;
    logic [DW-1:0] avg;
    logic [31:0]   stamp;
  } frame_t;

  frame_t      sb[$];
  frame_t      last_m;
  int          cnt_m;
  int          acc_m[CH];
  logic [31:0] stamp_m;
  logic        ovf_m;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    last_m.pt    = '0;
    last_m.avg   = '0;
    last_m.stamp = '0;
    cnt_m   = 0;
    for (int c = 0; c < CH; c++) acc_m[c] = 0;
    stamp_m = '0;
    ovf_m   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(valid_pt | valid_avg), 64'd0);
    check_eq({tag, "_level"}, 64'({level_pt, level_avg}), 64'd0);
    check_eq({tag, "_ovf"},   64'(ovf_pt | ovf_avg), 64'd0);
    check_eq({tag, "_data"},  64'({data_pt, data_avg}), 64'd0);
    check_eq({tag, "_stamp"}, 64'({stamp_pt, stamp_avg}), 64'd0);
  endtask

  // Called at a falling edge with inputs already set: compare the current
  // outputs with the model, then advance the model over the next rising edge.
  task automatic tick();
    frame_t      f;
    logic [W-1:0] s;
    int          sum;
    logic        exp_valid;

    exp_valid = (sb.size() != 0);
    check_eq("valid_pt",  64'(valid_pt),  64'(exp_valid));
    check_eq("valid_avg", 64'(valid_avg), 64'(exp_valid));
    check_eq("level_pt",  64'(level_pt),  64'(sb.size()));
    check_eq("level_avg", 64'(level_avg), 64'(sb.size()));
    check_eq("ovf_pt",    64'(ovf_pt),    64'(ovf_m));
    check_eq("ovf_avg",   64'(ovf_avg),   64'(ovf_m));
    if (exp_valid) begin
      check_eq("data_pt",   64'(data_pt),   64'(sb[0].pt));
      check_eq("data_avg",  64'(data_avg),  64'(sb[0].avg));
      check_eq("stamp_pt",  64'(stamp_pt),  64'(sb[0].stamp));
      check_eq("stamp_avg", 64'(stamp_avg), 64'(sb[0].stamp));
    end else begin
      check_eq("hold_pt",    64'(data_pt),   64'(last_m.pt));
      check_eq("hold_avg",   64'(data_avg),  64'(last_m.avg));
      check_eq("hold_stamp", 64'(stamp_pt),  64'(last_m.stamp));
    end

    if (exp_valid && ready) begin
      last_m = sb.pop_front();
      $display("pop stamp=%0d pt=%h avg=%h", last_m.stamp, last_m.pt, last_m.avg);
    end

    if (en) begin
      if (cnt_m == DIV - 1) begin
        f.pt    = samples;
        f.avg   = '0;
        f.stamp = stamp_m;
        for (int c = 0; c < CH; c++) begin
          s   = samples[c*W +: W];
          sum = acc_m[c] + int'(s);
          f.avg[c*W +: W] = W'(sum / DIV);
          acc_m[c] = 0;
        end
        if (sb.size() < DEPTH) sb.push_back(f);
        else ovf_m = 1'b1;
        stamp_m = stamp_m + 32'd1;
        cnt_m   = 0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          s = samples[c*W +: W];
          acc_m[c] += int'(s);
        end
        cnt_m++;
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int seq[4] = '{1, 2, 3, 6};

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Point sampling of a ramp and averaging of a period-4 pattern.
    en = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      samples = {4'hA, 4'(i)};
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      samples = {4'hF, 4'(seq[i % 4])};
      tick();
    end

    // Back-pressure: 6 strobes with no consumer, then drain.
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 6 * DIV; i++) begin
      samples = DW'($urandom);
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      samples = DW'($urandom);
      tick();
    end

    // Full FIFO with strobe and pop in the same cycle.
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (sb.size() == DEPTH && cnt_m == DIV - 1) break;
      samples = DW'($urandom);
      tick();
    end
    check_eq("t5_setup", 64'(sb.size() == DEPTH && cnt_m == DIV - 1), 64'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (3) tick();

    // en gating mid-window.
    ready = 1'b1;
    repeat (2) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      samples = DW'($urandom);
      tick();
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      samples = DW'($urandom);
      tick();
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      ready   = ($urandom_range(0, 1) != 0);
      samples = DW'($urandom);
      tick();
    end

    // Asynchronous reset mid-window with frames held and overflow set.
    en = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      samples = DW'($urandom);
      tick();
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      samples = DW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
